// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs bytes from the UART receiver into fixed-size words.
// The first byte received lands in the MSBs. Finished words are offered on a
// valid/ready port. A partial word is dropped if the line goes idle too long.
module uart_word_assembler #(
    parameter int unsigned CLOCK_RATE     = 10_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_BYTES  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data,
    input  logic                          dataIsValid,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          wordIsValid,
    input  logic                          wordReady,
    output logic                          overflow,
    output logic                          timeout
);

    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
    // Only the bytes that precede the final one need to be stored.
    localparam int unsigned SR_W   = WORD_W - 8;
    localparam int unsigned COUNT_W = (BYTES_PER_WORD > 2) ? $clog2(BYTES_PER_WORD) : 1;
    // Idle limit is a whole number of 10-bit frames at the line rate.
    localparam int unsigned TIMEOUT_CYCLES =
        32'((64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLOCK_RATE)) / 64'(BAUD_RATE));
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [COUNT_W-1:0] LAST_COUNT   = COUNT_W'(BYTES_PER_WORD - 1);
    localparam logic [IDLE_W-1:0]  TIMEOUT_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } stateType;

    stateType           state;
    logic               prevValid;
    logic [SR_W-1:0]    sr;
    logic [COUNT_W-1:0] count;
    logic [IDLE_W-1:0]  idleCount;
    logic               capture;

    // A byte is taken only on the rising edge of dataIsValid.
    assign capture = dataIsValid && !prevValid;

    // Assembly FSM, idle timer and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prevValid   <= 1'b1;
            sr          <= '0;
            count       <= '0;
            idleCount   <= '0;
            word        <= '0;
            wordIsValid <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            prevValid <= dataIsValid;
            overflow  <= 1'b0;
            timeout   <= 1'b0;

            if (wordIsValid && wordReady) begin
                wordIsValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    count     <= '0;
                    idleCount <= '0;
                    if (capture) begin
                        sr    <= SR_W'(data);
                        count <= COUNT_W'(1);
                        state <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (capture) begin
                        idleCount <= '0;
                        if (count == LAST_COUNT) begin
                            count <= '0;
                            sr    <= '0;
                            state <= IDLE;
                            // Load if the slot is empty or being freed this cycle.
                            if (!wordIsValid || wordReady) begin
                                word        <= {sr, data};
                                wordIsValid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            sr    <= SR_W'({sr, data});
                            count <= count + COUNT_W'(1);
                        end
                    end else if (idleCount == TIMEOUT_LAST) begin
                        timeout   <= 1'b1;
                        idleCount <= '0;
                        count     <= '0;
                        sr        <= '0;
                        state     <= IDLE;
                    end else begin
                        idleCount <= idleCount + IDLE_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
